// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default widths.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_ADDR_WIDTH     = 10;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// Channel-wait watchdog: cleared on state entry, counts while enabled, flags expiry.
module axi_lite_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry is decided one count early so the registered abort lands on cycle TIMEOUT_CYCLES.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite configuration master with registered outputs and watchdog abort.
module axi_lite_cfg_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

    logic aw_pending, w_pending, abort, tmo_clr, tmo_en, tmo_expire;

    assign aw_pending = awvalid_q & ~m_axi_awready;
    assign w_pending  = wvalid_q & ~m_axi_wready;
    assign tmo_en     = (state_q != ST_IDLE);
    assign tmo_clr    = (state_d != state_q);

    axi_lite_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (axi_clk),
        .rst_ni  (axi_reset_n),
        .clr_i   (tmo_clr),
        .en_i    (tmo_en),
        .expire_o(tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        abort       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_AW_W;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W retire independently; a dropped valid marks its channel done.
                if (!aw_pending && !w_pending) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_B;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end else begin
                    awvalid_d = aw_pending;
                    wvalid_d  = w_pending;
                end
            end
            ST_WR_B: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = resp_is_err(m_axi_bresp);
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (m_axi_arready && arvalid_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            ST_RD_R: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = resp_is_err(m_axi_rresp);
                    rsp_rdata_d = m_axi_rdata;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master: handshake ordering, latency, error, timeout and reset cases.
module tb_axi_lite_cfg_master;
    import axi_lite_pkg::*;

    logic        axi_clk;
    logic        axi_reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [9:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    axi_lite_cfg_master #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (10),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command for one edge; on return the DUT is in its first post-accept cycle.
    task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        axi_reset_n   = 1'b0;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = RESP_OKAY;
        m_axi_bvalid  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = RESP_OKAY;
        m_axi_rvalid  = 1'b0;
        repeat (3) tick();

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_error}, 0);
        chk("rst_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_rdata}, 0);
        axi_reset_n = 1'b1;
        tick();

        // Write, always-ready slave
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        issue(1'b1, 10'h0A5, 32'hDEADBEEF);
        chk("w1_c1_valids", {cmd_ready, m_axi_awvalid, m_axi_wvalid}, 3'b011);
        chk("w1_awaddr", m_axi_awaddr, 10'h0A5);
        chk("w1_wdata", m_axi_wdata, 32'hDEADBEEF);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = RESP_OKAY;
        tick();
        chk("w1_c2", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid}, 4'b0010);
        tick();
        m_axi_bvalid = 1'b0;
        chk("w1_c3_rsp", {rsp_valid, rsp_error, cmd_ready, m_axi_bready}, 4'b1010);
        chk("w1_rdata", rsp_rdata, 0);
        tick();
        chk("w1_c4_pulse", rsp_valid, 0);

        // Write, awready delayed 4 cycles, wready immediate
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b1;
        issue(1'b1, 10'h1F0, 32'hCAFEF00D);
        chk("w2_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("w2_c%0d_aw", c), {m_axi_awvalid, m_axi_wvalid, rsp_valid, m_axi_awaddr},
                {3'b100, 10'h1F0});
        end
        m_axi_awready = 1'b1;
        tick();
        chk("w2_c6", {m_axi_awvalid, m_axi_bready}, 2'b01);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("w2_rsp", {rsp_valid, rsp_error}, 2'b10);
        tick();
        chk("w2_single", rsp_valid, 0);

        // Read, arready after 2 cycles
        m_axi_arready = 1'b0;
        issue(1'b0, 10'h010, 32'h0);
        chk("r1_c1", {cmd_ready, m_axi_arvalid, m_axi_araddr}, {2'b01, 10'h010});
        tick();
        chk("r1_c2", m_axi_arvalid, 1);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("r1_c3", {m_axi_arvalid, m_axi_rready}, 2'b01);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h12345678;
        m_axi_rresp  = RESP_OKAY;
        tick();
        m_axi_rvalid = 1'b0;
        chk("r1_rsp", {rsp_valid, rsp_error, m_axi_rready}, 3'b100);
        chk("r1_rdata", rsp_rdata, 32'h12345678);

        // Read with SLVERR
        m_axi_arready = 1'b1;
        issue(1'b0, 10'h020, 32'h0);
        tick();
        chk("r2_rready", m_axi_rready, 1);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hA5A50001;
        m_axi_rresp  = RESP_SLVERR;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_arready = 1'b0;
        chk("r2_rsp", {rsp_valid, rsp_error}, 2'b11);
        chk("r2_rdata", rsp_rdata, 32'hA5A50001);
        tick();
        chk("r2_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'hA5A50001});

        // Silent slave: write times out
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        issue(1'b1, 10'h3FF, 32'h0F0F0F0F);
        repeat (14) tick();
        chk("to_c15", {rsp_valid, m_axi_awvalid, m_axi_wvalid, cmd_ready}, 4'b0110);
        tick();
        chk("to_c16_rsp", {rsp_valid, rsp_error, cmd_ready}, 3'b111);
        chk("to_c16_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk("to_rdata", rsp_rdata, 0);

        // Write with DECERR
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        issue(1'b1, 10'h044, 32'h00000001);
        tick();
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = RESP_DECERR;
        tick();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = RESP_OKAY;
        chk("dec_rsp", {rsp_valid, rsp_error}, 2'b11);

        // B handshake on the expiry cycle completes normally
        issue(1'b1, 10'h055, 32'h00000002);
        tick();
        chk("hw_c2", m_axi_bready, 1);
        repeat (14) tick();
        chk("hw_c16", {rsp_valid, m_axi_bready}, 2'b01);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("hw_rsp", {rsp_valid, rsp_error}, 2'b10);

        // Reset in WR_B, then back-to-back read and write
        issue(1'b1, 10'h2AA, 32'h11112222);
        tick();
        chk("rs_wr_b", m_axi_bready, 1);
        axi_reset_n = 1'b0;
        #1;
        chk("rs_async", {m_axi_bready, cmd_ready, rsp_valid, m_axi_awaddr}, {3'b010, 10'h000});
        tick();
        axi_reset_n = 1'b1;
        tick();
        chk("rs_no_rsp", {rsp_valid, cmd_ready}, 2'b01);

        m_axi_arready = 1'b1;
        issue(1'b0, 10'h030, 32'h0);
        tick();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h0BADCAFE;
        m_axi_rresp  = RESP_OKAY;
        tick();
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
        chk("b2b_rd_rsp", {rsp_valid, rsp_error, cmd_ready, rsp_rdata}, {3'b101, 32'h0BADCAFE});
        issue(1'b1, 10'h040, 32'h55AA55AA);
        chk("b2b_wr_c1", {rsp_valid, cmd_ready, m_axi_awvalid, m_axi_awaddr}, {3'b001, 10'h040});
        chk("b2b_wr_data", m_axi_wdata, 32'h55AA55AA);
        m_axi_bvalid = 1'b1;
        tick();
        tick();
        m_axi_bvalid = 1'b0;
        chk("b2b_wr_rsp", {rsp_valid, rsp_error, cmd_ready, rsp_rdata}, {3'b101, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
